// File: rtl/time_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : time_pkg                                                    |
// | Shared definitions for the time-of-week keeper: set-mode field       |
// | codes, CT word bit positions, reset value and counting limits.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package time_pkg;

    typedef enum logic [1:0] {
        FIELD_MIN  = 2'b00,
        FIELD_HOUR = 2'b01,
        FIELD_DAY  = 2'b10,
        FIELD_NONE = 2'b11
    } field_t;

    // CT word layout
    localparam int CT_DAY_MSB  = 14;
    localparam int CT_DAY_LSB  = 12;
    localparam int CT_HOUR_MSB = 11;   // hour tens (1 bit) + hour units (4 bits)
    localparam int CT_HOUR_LSB = 7;
    localparam int CT_MIN_MSB  = 6;    // minute tens (3 bits) + minute units (4 bits)
    localparam int CT_MIN_LSB  = 0;

    // Day 0, 12:00
    localparam logic [14:0] CT_RESET = 15'h0900;

    localparam int DAYS = 7;
    localparam int SECS = 60;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tick_prescaler                                              |
// | Divides Clk down to a one-cycle tick every TICKS_PER_SEC cycles.     |
// | Ports  : Clk  - clock                                                |
// |          Clr  - asynchronous active-low reset                        |
// |          hold - forces the count to 0 and suppresses tick            |
// |          tick - high for the cycle in which count = TICKS_PER_SEC-1  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic Clk,
    input  logic Clr,
    input  logic hold,
    output logic tick
);

    localparam int              CW   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            count <= '0;
        end else if (hold || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Combinational so that raising hold in a would-be tick cycle kills it.
    assign tick = !hold && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : time_keeper                                                 |
// | Time-of-week counter: BCD minutes, 12-hour BCD hours with PM flag,   |
// | day of week, plus a set mode for manual adjustment.                  |
// | Ports  : Clk   - clock                                               |
// |          Clr   - asynchronous active-low reset                       |
// |          SetEn - 1 = set mode (time frozen), 0 = run                 |
// |          Field - set field: 00 min, 01 hour, 10 day, 11 none         |
// |          Inc   - increment request, acts on its rising edge          |
// |          CT    - {day[2:0], hour BCD[4:0], minute BCD[6:0]}          |
// |          PM    - 1 = PM                                              |
// |          Tick  - one-cycle pulse per second in run mode              |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module time_keeper
    import time_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        SetEn,
    input  logic [1:0]  Field,
    input  logic        Inc,
    output logic [14:0] CT,
    output logic        PM,
    output logic        Tick
);

    localparam logic [6:0] MIN_59  = 7'h59;
    localparam logic [4:0] HOUR_11 = 5'h11;
    localparam logic [4:0] HOUR_12 = 5'h12;

    logic [2:0] day,   day_n;
    logic [4:0] hour,  hour_n;   // {tens, units}
    logic [6:0] min,   min_n;    // {tens[2:0], units[3:0]}
    logic [5:0] sec,   sec_n;
    logic       pm,    pm_n;
    logic       inc_d;
    logic       inc_rise;
    logic       tick;

    tick_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_prescaler (
        .Clk  (Clk),
        .Clr  (Clr),
        .hold (SetEn),
        .tick (tick)
    );

    function automatic logic [6:0] min_inc(input logic [6:0] m);
        if (m[3:0] != 4'd9) begin
            return {m[6:4], m[3:0] + 4'd1};
        end else if (m[6:4] != 3'd5) begin
            return {m[6:4] + 3'd1, 4'd0};
        end else begin
            return 7'h00;
        end
    endfunction

    // 12-hour sequence 12,1,...,9,10,11,12
    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        if (h == HOUR_12) begin
            return 5'h01;
        end else if (h[3:0] == 4'd9) begin
            return 5'h10;
        end else begin
            return {h[4], h[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [2:0] day_inc(input logic [2:0] d);
        return (d == 3'(DAYS - 1)) ? 3'd0 : d + 3'd1;
    endfunction

    // inc_d follows Inc in both modes, so an Inc already high when SetEn
    // rises is not seen as an edge.
    assign inc_rise = Inc && !inc_d;

    always_comb begin
        day_n  = day;
        hour_n = hour;
        min_n  = min;
        sec_n  = sec;
        pm_n   = pm;
        if (SetEn) begin
            sec_n = '0;
            if (inc_rise) begin
                case (field_t'(Field))
                    FIELD_MIN:  min_n = min_inc(min);
                    FIELD_HOUR: begin
                        hour_n = hour_inc(hour);
                        if (hour == HOUR_11) begin
                            pm_n = !pm;
                        end
                    end
                    FIELD_DAY:  day_n = day_inc(day);
                    default:    ;
                endcase
            end
        end else if (tick) begin
            if (sec == 6'(SECS - 1)) begin
                sec_n = '0;
                min_n = min_inc(min);
                if (min == MIN_59) begin
                    hour_n = hour_inc(hour);
                    if (hour == HOUR_11) begin
                        pm_n = !pm;
                        // PM -> AM is midnight
                        if (pm) begin
                            day_n = day_inc(day);
                        end
                    end
                end
            end else begin
                sec_n = sec + 6'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            day   <= CT_RESET[CT_DAY_MSB:CT_DAY_LSB];
            hour  <= CT_RESET[CT_HOUR_MSB:CT_HOUR_LSB];
            min   <= CT_RESET[CT_MIN_MSB:CT_MIN_LSB];
            sec   <= '0;
            pm    <= 1'b0;
            inc_d <= 1'b0;
        end else begin
            day   <= day_n;
            hour  <= hour_n;
            min   <= min_n;
            sec   <= sec_n;
            pm    <= pm_n;
            inc_d <= Inc;
        end
    end

    assign CT[CT_DAY_MSB:CT_DAY_LSB]   = day;
    assign CT[CT_HOUR_MSB:CT_HOUR_LSB] = hour;
    assign CT[CT_MIN_MSB:CT_MIN_LSB]   = min;
    assign PM                          = pm;
    assign Tick                        = tick;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_time_keeper                                              |
// | Self-checking bench for time_keeper with TICKS_PER_SEC = 4. A        |
// | behavioural model produces the expected {CT, PM, Tick} for every     |
// | cycle into a scoreboard queue; named checkpoints add fixed values.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_time_keeper;

    localparam int T = 4;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        SetEn;
    logic [1:0]  Field;
    logic        Inc;
    logic [14:0] CT;
    logic        PM;
    logic        Tick;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: plain integers, converted to BCD only for comparison
    int   m_cnt, m_sec, m_min, m_hour, m_day;
    logic m_pm, m_inc_prev;

    logic [16:0] exp_q[$];

    time_keeper #(
        .TICKS_PER_SEC (T)
    ) dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .SetEn (SetEn),
        .Field (Field),
        .Inc   (Inc),
        .CT    (CT),
        .PM    (PM),
        .Tick  (Tick)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt      = 0;
        m_sec      = 0;
        m_min      = 0;
        m_hour     = 12;
        m_day      = 0;
        m_pm       = 1'b0;
        m_inc_prev = 1'b0;
    endtask

    function automatic logic [14:0] model_ct();
        logic [2:0] d;
        logic       ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
        d  = 3'(m_day);
        ht = (m_hour >= 10);
        hu = 4'(m_hour % 10);
        mt = 3'(m_min / 10);
        mu = 4'(m_min % 10);
        return {d, ht, hu, mt, mu};
    endfunction

    function automatic int next_hour(input int h);
        return (h == 12) ? 1 : h + 1;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic tk;
        tk = !SetEn && (m_cnt == T - 1);
        if (SetEn) begin
            m_cnt = 0;
            m_sec = 0;
            if (Inc && !m_inc_prev) begin
                case (Field)
                    2'b00: m_min = (m_min + 1) % 60;
                    2'b01: begin
                        if (m_hour == 11) m_pm = ~m_pm;
                        m_hour = next_hour(m_hour);
                    end
                    2'b10: m_day = (m_day + 1) % 7;
                    default: ;
                endcase
            end
        end else begin
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) begin
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0;
                    m_min++;
                    if (m_min == 60) begin
                        m_min = 0;
                        if (m_hour == 11) begin
                            if (m_pm) m_day = (m_day + 1) % 7;
                            m_pm = ~m_pm;
                        end
                        m_hour = next_hour(m_hour);
                    end
                end
            end
        end
        m_inc_prev = Inc;
    endtask

    task automatic step();
        logic [16:0] e;
        logic [16:0] g;
        model_step();
        exp_q.push_back({model_ct(), m_pm, (!SetEn && (m_cnt == T - 1))});
        @(posedge Clk);
        #1;
        g = {CT, PM, Tick};
        e = exp_q.pop_front();
        check_eq("cycle", 32'(g), 32'(e));
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            Inc = 1'b1;
            step();
            Inc = 1'b0;
            step();
        end
    endtask

    initial begin
        Clr   = 1'b1;
        SetEn = 1'b0;
        Field = 2'b11;
        Inc   = 1'b0;
        model_reset();

        // reset, asynchronous entry and held
        #1 Clr = 1'b0;
        #1;
        check_eq("rst_ct_async", 32'(CT), 32'h0900);
        check_eq("rst_pm_async", 32'(PM), 32'h0);
        check_eq("rst_tick_async", 32'(Tick), 32'h0);
        repeat (2) begin
            @(posedge Clk);
            #1;
            check_eq("rst_ct", 32'(CT), 32'h0900);
            check_eq("rst_pm", 32'(PM), 32'h0);
        end
        Clr = 1'b1;

        // one minute of run time; tick on every 4th cycle starting at the 4th
        for (int i = 1; i <= 240; i++) begin
            step();
            if (i <= 12) check_eq("tick_pat", 32'(Tick), 32'(i % 4 == 3));
        end
        check_eq("run240_ct", 32'(CT), 32'h0901);
        check_eq("run240_pm", 32'(PM), 32'h0);

        // program day 6, 11:59 PM
        SetEn = 1'b1;
        step();
        Field = 2'b00; pulse(58);
        Field = 2'b01; pulse(23);
        Field = 2'b10; pulse(6);
        Field = 2'b11; pulse(2);
        check_eq("prog_ct", 32'(CT), 32'h68D9);
        check_eq("prog_pm", 32'(PM), 32'h1);

        // midnight rollover; Inc toggling in run mode is ignored
        SetEn = 1'b0;
        for (int i = 1; i <= 240; i++) begin
            Inc = (i % 7 == 0);
            step();
        end
        Inc = 1'b0;
        check_eq("roll_ct", 32'(CT), 32'h0900);
        check_eq("roll_pm", 32'(PM), 32'h0);

        // SetEn raised while Inc already high: no increment
        Inc = 1'b1;
        step();
        SetEn = 1'b1;
        Field = 2'b00;
        repeat (3) step();
        Inc = 1'b0;
        step();
        check_eq("noedge_ct", 32'(CT), 32'h0900);

        // minute set 59 -> 00 without hour carry
        pulse(59);
        check_eq("min59_ct", 32'(CT), 32'h0959);
        pulse(1);
        check_eq("minwrap_ct", 32'(CT), 32'h0900);
        check_eq("set_tick", 32'(Tick), 32'h0);

        // hour set to 11 AM, then Inc held high gives exactly one step
        Field = 2'b01;
        pulse(11);
        check_eq("h11_ct", 32'(CT), 32'h0880);
        check_eq("h11_pm", 32'(PM), 32'h0);
        Inc = 1'b1;
        repeat (20) step();
        Inc = 1'b0;
        step();
        check_eq("hold_ct", 32'(CT), 32'h0900);
        check_eq("hold_pm", 32'(PM), 32'h1);

        // day set 6 -> 0
        Field = 2'b10;
        pulse(6);
        check_eq("day6_ct", 32'(CT), 32'h6900);
        pulse(1);
        check_eq("day0_ct", 32'(CT), 32'h0900);
        Field = 2'b00;
        pulse(1);
        check_eq("pre_arst_ct", 32'(CT), 32'h0901);

        // run, then reset asynchronously mid tick period
        SetEn = 1'b0;
        Field = 2'b11;
        repeat (6) step();
        #3 Clr = 1'b0;
        #1;
        check_eq("arst_ct", 32'(CT), 32'h0900);
        check_eq("arst_pm", 32'(PM), 32'h0);
        check_eq("arst_tick", 32'(Tick), 32'h0);
        model_reset();
        #2 Clr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("rel_tick", 32'(Tick), 32'(i == 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_keeper.md
Name: time_keeper

Overview:
Real-time-of-week counter that produces the current-time word CT and the PM flag consumed by display_module.
- Divides Clk down to a 1 Hz tick.
- Counts seconds (internal), minutes and 12-hour hours in BCD, plus day-of-week.
- Supports a user set mode: a selected field increments on each Inc press while timekeeping is frozen.

Parameters:
- TICKS_PER_SEC, 50000000, Clk cycles per second. Minimum 2. Bench uses 4.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Clr  input  1  asynchronous, active-low reset.
- SetEn  input  1  1 = set mode (timekeeping frozen); 0 = run.
- Field  input  2  set-mode field select: 00 minute, 01 hour, 10 day, 11 none.
- Inc  input  1  increment request, level; synchronous; acts on its rising edge.
- CT  output  15  current time:
  - [14:12] day 0..6
  - [11] hour tens 0..1
  - [10:7] hour units 0..9
  - [6:4] minute tens 0..5
  - [3:0] minute units 0..9
- PM  output  1  0 = AM, 1 = PM.
- Tick  output  1  one-cycle pulse at each second boundary in run mode.

Behaviour:
- Reset (Clr=0, async):
  - CT=15'h0900 (day 0, 12:00), PM=0, Tick=0.
  - Prescaler=0, seconds=0, Inc edge register=0.
  - Release is synchronous to the next Clk edge.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 and wraps.
  - Tick=1 for the single cycle in which the count equals TICKS_PER_SEC-1 while SetEn=0.
  - First Tick occurs TICKS_PER_SEC cycles after reset release.
- Run mode (SetEn=0), on Tick:
  - seconds 0..59 increments.
  - 59->0 carries into minutes.
- Minutes (BCD):
  - units 9->0 with carry into tens.
  - 59->00 carries into hours.
- Hours (BCD, 12-hour):
  - Sequence 12,1,2,...,11,12.
  - 9->10 sets tens=1, units=0.
  - 12->1 sets tens=0, units=1.
  - 11->12 toggles PM.
- Day:
  - Increments only when PM toggles 1->0 (11:59:59 PM -> 12:00:00 AM).
  - Wraps 6->0.
- All carries in one chain resolve in the same cycle. CT/PM update on the Clk edge that samples Tick=1, so outputs change one cycle after Tick asserts.
- Set mode (SetEn=1):
  - Prescaler and seconds are held at 0; Tick=0.
  - Inc rising edge, detected via a 1-cycle-delayed register, increments the Field-selected value on the next edge.
  - Minute set: 59->00, no carry into hour.
  - Hour set: follows the 12-hour sequence and toggles PM at 11->12; never advances day.
  - Day set: 6->0.
  - Field=11: no change.
  - Inc held high produces exactly one increment.
- Leaving set mode (SetEn 1->0):
  - Prescaler restarts from 0.
  - First Tick occurs TICKS_PER_SEC cycles later; seconds start at 0.
- Inc edges while SetEn=0 are ignored, but the edge register still tracks Inc. Raising SetEn while Inc is already high does not produce an increment.
- Entering set mode on the cycle a Tick would occur suppresses that Tick; time does not advance.
- Reset mid-operation: all state returns to reset values immediately, regardless of mode.
- No invalid BCD value is ever output. Values are only ever produced by the legal sequences.

Decomposition:
- Shared package time_pkg:
  - Field codes FIELD_MIN=2'b00, FIELD_HOUR=2'b01, FIELD_DAY=2'b10, FIELD_NONE=2'b11.
  - CT bit-slice positions.
  - Reset constant CT_RESET=15'h0900.
  - Constants DAYS=7, SECS=60.
- One sub-module, tick_prescaler (parameter TICKS_PER_SEC).
  - Inputs: Clk, Clr, hold.
  - Output: tick.
  - Shared with any future alarm/snooze timer.
- BCD increment logic stays inline as functions or always-block code.

Test Plan:
- Reset, TICKS_PER_SEC=4:
  - CT=15'h0900 and PM=0 during and after reset.
  - First Tick at cycle 4 after release.
  - Tick period exactly 4 cycles.
- Run 240 cycles from reset -> CT minute field=01 (CT=15'h0901), PM=0.
- Use set mode to program 11:59 PM day 6 (Field=01 Inc x11 then x12 via 11->12 toggle to PM...; or direct sequence to reach PM=1, hour 11, minute 59, day 6), release SetEn, run 240 cycles -> CT=15'h0900 (day 0, 12:00), PM=0.
- Set mode, Field=00, from minute 59, one Inc pulse -> minute 00, hour unchanged, seconds held, Tick stays 0 throughout set mode.
- Set mode, Field=01, from 11 AM, Inc held high 20 cycles -> exactly one increment: hour 12, PM=1, day unchanged.
- Set mode, Field=10, from day 6, Inc -> day 0.
- Assert Clr low mid-way through a Tick period in run mode -> outputs return to 15'h0900/PM=0 asynchronously (before the next Clk edge).
